// File: rtl/apb_pkg.sv
// Shared definitions for the multi-slave APB master: FSM states,
// response codes and the slave-index width helper.
package apb_pkg;

    // Bus phase of the master.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    // Internal response codes; rsp_err is any code other than OKAY.
    localparam logic [1:0] OKAY    = 2'd0;
    localparam logic [1:0] SLVERR  = 2'd1;
    localparam logic [1:0] DECERR  = 2'd2;
    localparam logic [1:0] TIMEOUT = 2'd3;

    // Width of the slave index field; a single slave still gets one bit.
    function automatic int APB_SEL_W(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/apb_master_mc_mux.sv
// Slave decode and return mux: turns a request index into a mapped flag,
// the latched index into a one-hot select, and picks the selected slave's
// pready/prdata/pslverr.
module apb_slave_mux
    import apb_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int NUM_SLAVES = 4,
    parameter int SEL_W      = APB_SEL_W(NUM_SLAVES)
) (
    input  logic [SEL_W-1:0]             req_idx_i,
    input  logic [SEL_W-1:0]             sel_idx_i,
    input  logic [NUM_SLAVES-1:0]        pready_i,
    input  logic [NUM_SLAVES*DATA_W-1:0] prdata_i,
    input  logic [NUM_SLAVES-1:0]        pslverr_i,
    output logic                         req_mapped_o,
    output logic [NUM_SLAVES-1:0]        psel_onehot_o,
    output logic                         pready_o,
    output logic [DATA_W-1:0]            prdata_o,
    output logic                         pslverr_o
);

    // Index decode; a lone slave answers every index, otherwise indices past
    // the last slave match nothing and are reported as unmapped.
    always_comb begin
        req_mapped_o  = 1'b0;
        psel_onehot_o = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if ((NUM_SLAVES == 1) || (req_idx_i == SEL_W'(i))) begin
                req_mapped_o = 1'b1;
            end
            if ((NUM_SLAVES == 1) || (sel_idx_i == SEL_W'(i))) begin
                psel_onehot_o[i] = 1'b1;
            end
        end
    end

    // Return path from the currently selected slave only.
    always_comb begin
        pready_o  = 1'b0;
        prdata_o  = '0;
        pslverr_o = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (psel_onehot_o[i]) begin
                pready_o  = pready_i[i];
                prdata_o  = prdata_i[i*DATA_W +: DATA_W];
                pslverr_o = pslverr_i[i];
            end
        end
    end

endmodule

// File: rtl/apb_master_mc.sv
// Multi-slave APB master: one transfer at a time from a valid/ready request
// port, SETUP/ACCESS sequencing, decode errors and a one-cycle response.
// Optional ACCESS wait-state timeout: define APB_MASTER_TIMEOUT_EN.
module apb_master_mc
    import apb_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int NUM_SLAVES     = 4,
    parameter int SEL_LSB        = 12,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                         pclk,
    input  logic                         preset,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_write,
    input  logic [ADDR_W-1:0]            req_addr,
    input  logic [DATA_W-1:0]            req_wdata,
    input  logic [DATA_W/8-1:0]          req_strb,
    output logic                         rsp_valid,
    output logic [DATA_W-1:0]            rsp_rdata,
    output logic                         rsp_err,
    output logic                         rsp_timeout,
    output logic [NUM_SLAVES-1:0]        psel,
    output logic                         penable,
    output logic                         pwrite,
    output logic [ADDR_W-1:0]            paddr,
    output logic [DATA_W-1:0]            pwdata,
    output logic [DATA_W/8-1:0]          pstrb,
    input  logic [NUM_SLAVES-1:0]        pready,
    input  logic [NUM_SLAVES*DATA_W-1:0] prdata,
    input  logic [NUM_SLAVES-1:0]        pslverr
);

    localparam int STRB_W = DATA_W / 8;
    localparam int SEL_W  = APB_SEL_W(NUM_SLAVES);

    apb_state_e          state_q, state_d;
    logic [SEL_W-1:0]    idx_q;
    logic [ADDR_W-1:0]   paddr_q;
    logic                pwrite_q;
    logic [DATA_W-1:0]   pwdata_q;
    logic [STRB_W-1:0]   pstrb_q;
    logic                rsp_valid_q;
    logic [1:0]          rsp_code_q;
    logic [DATA_W-1:0]   rsp_rdata_q;
    logic                decerr_pend_q;

    logic [SEL_W-1:0]      req_idx;
    logic                  req_mapped;
    logic [NUM_SLAVES-1:0] sel_onehot;
    logic                  pready_sel;
    logic [DATA_W-1:0]     prdata_sel;
    logic                  pslverr_sel;
    logic                  accept;
    logic                  complete;
    logic                  timeout_hit;

    assign req_idx = req_addr[SEL_LSB +: SEL_W];

    apb_slave_mux #(
        .DATA_W     (DATA_W),
        .NUM_SLAVES (NUM_SLAVES),
        .SEL_W      (SEL_W)
    ) u_mux (
        .req_idx_i     (req_idx),
        .sel_idx_i     (idx_q),
        .pready_i      (pready),
        .prdata_i      (prdata),
        .pslverr_i     (pslverr),
        .req_mapped_o  (req_mapped),
        .psel_onehot_o (sel_onehot),
        .pready_o      (pready_sel),
        .prdata_o      (prdata_sel),
        .pslverr_o     (pslverr_sel)
    );

    assign accept   = req_valid && req_ready;
    assign complete = (state_q == ACCESS) && pready_sel;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

    // Wait-state counter: restarts with each SETUP, counts stalled ACCESS cycles.
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (state_q == SETUP) begin
            tmo_cnt_d = '0;
        end else if ((state_q == ACCESS) && !pready_sel) begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
    end

    // Wait-state counter register.
    always_ff @(posedge pclk) begin
        if (preset) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    // The stalled cycle that would make the count reach the limit is the last
    // one; a pready in that same cycle still completes normally.
    assign timeout_hit = (state_q == ACCESS) && !pready_sel &&
                         (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
    assign rsp_timeout = (rsp_code_q == TIMEOUT);
`else
    assign timeout_hit = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; an unmapped request never leaves IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept && req_mapped) begin
                    state_d = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (pready_sel) begin
                    state_d = (accept && req_mapped) ? SETUP : IDLE;
                end else if (timeout_hit) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM outputs; ready is held low while a queued decode error drains so
    // two responses can never land on the same cycle.
    always_comb begin
        psel      = '0;
        penable   = 1'b0;
        req_ready = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = !preset && !decerr_pend_q;
            end
            SETUP: begin
                psel = sel_onehot;
            end
            ACCESS: begin
                psel      = sel_onehot;
                penable   = 1'b1;
                req_ready = !preset && pready_sel;
            end
            default: begin
                psel = '0;
            end
        endcase
    end

    // Bus field capture and response generation.
    always_ff @(posedge pclk) begin
        if (preset) begin
            idx_q         <= '0;
            paddr_q       <= '0;
            pwrite_q      <= 1'b0;
            pwdata_q      <= '0;
            pstrb_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_code_q    <= OKAY;
            rsp_rdata_q   <= '0;
            decerr_pend_q <= 1'b0;
        end else begin
            rsp_valid_q   <= 1'b0;
            rsp_code_q    <= OKAY;
            rsp_rdata_q   <= '0;
            decerr_pend_q <= 1'b0;

            if (accept && req_mapped) begin
                idx_q    <= req_idx;
                paddr_q  <= req_addr;
                pwrite_q <= req_write;
                pwdata_q <= req_wdata;
                pstrb_q  <= req_write ? req_strb : '0;
            end

            if (complete) begin
                rsp_valid_q <= 1'b1;
                rsp_code_q  <= pslverr_sel ? SLVERR : OKAY;
                rsp_rdata_q <= (!pwrite_q && !pslverr_sel) ? prdata_sel : '0;
            end else if (timeout_hit) begin
                rsp_valid_q <= 1'b1;
                rsp_code_q  <= TIMEOUT;
            end else if (decerr_pend_q) begin
                rsp_valid_q <= 1'b1;
                rsp_code_q  <= DECERR;
            end

            if (accept && !req_mapped) begin
                if (complete) begin
                    decerr_pend_q <= 1'b1;
                end else begin
                    rsp_valid_q <= 1'b1;
                    rsp_code_q  <= DECERR;
                end
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = (rsp_code_q != OKAY);
    assign rsp_rdata = rsp_rdata_q;
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign pstrb     = pstrb_q;

endmodule

// File: doc/apb_master_mc.md
# apb_master_mc

Parametrised multi-slave APB master: accepts single transfers on a valid/ready request port, drives a standard APB SETUP/ACCESS sequence to one of `NUM_SLAVES` decoded slaves, and returns a one-cycle response with read data and error status. It replaces the single-slave master, adding width/slave-count generics, byte strobes, back-to-back transfers, decode errors and an optional wait-state timeout.

## Interface
- `ADDR_W`, 32, address width (bits).
- `DATA_W`, 32, data width; must be a multiple of 8.
- `NUM_SLAVES`, 4, number of slaves, 1..16.
- `SEL_LSB`, 12, lowest address bit of the slave index field.
- `TIMEOUT_CYCLES`, 256, ACCESS-state cycle limit; used only with timeout compiled in.
- `pclk` in 1, the block's single clock.
- `preset` in 1, synchronous, active-high reset.
- `req_valid` in 1, request present.
- `req_ready` out 1, request accepted on an edge where `req_valid && req_ready`.
- `req_write` in 1, 1 = write, 0 = read.
- `req_addr` in ADDR_W, transfer address.
- `req_wdata` in DATA_W, write data.
- `req_strb` in DATA_W/8, write byte strobes.
- `rsp_valid` out 1, one-cycle response pulse; no backpressure.
- `rsp_rdata` out DATA_W, read data; 0 for writes and errors.
- `rsp_err` out 1, slave error, decode error or timeout.
- `rsp_timeout` out 1, error was a timeout.
- `psel` out NUM_SLAVES, one-hot slave select.
- `penable` out 1, ACCESS phase.
- `pwrite`, `paddr` (ADDR_W), `pwdata` (DATA_W), `pstrb` (DATA_W/8) out, registered bus fields.
- `pready` in NUM_SLAVES, per-slave ready.
- `prdata` in NUM_SLAVES*DATA_W, slave i at bits [i*DATA_W +: DATA_W].
- `pslverr` in NUM_SLAVES, per-slave error.

## Operation
- States: IDLE, SETUP, ACCESS.
- Slave index `idx = req_addr[SEL_LSB +: clog2(NUM_SLAVES)]` (width 1 when NUM_SLAVES = 1). The index field is always that wide, so an index is unmapped only when NUM_SLAVES is not a power of two and `idx >= NUM_SLAVES`.
- `req_ready` = (IDLE) or (ACCESS and selected `pready` = 1).
- On accept with a mapped index: latch `paddr`, `pwrite`, `pwdata`, and `pstrb` (`req_strb` for writes, forced 0 for reads), then go to SETUP.
- On accept with an unmapped index: no bus cycle and no `psel`. Next cycle `rsp_valid`=1, `rsp_err`=1, `rsp_rdata`=0. State stays or returns to IDLE.
- SETUP: `psel[idx]`=1, `penable`=0, then go to ACCESS unconditionally.
- ACCESS: `psel[idx]`=1, `penable`=1. `pready`, `prdata` and `pslverr` are muxed from slave idx.
- While `pready`=0, stay in ACCESS with all bus fields stable.
- When `pready`=1: register the response (`rdata` only for reads; `rsp_err` = `pslverr`). If a new request is accepted in the same cycle, go to SETUP with the new fields (mapped) or to IDLE with a decode-error response queued (unmapped). Otherwise go to IDLE.
- A completion response and a decode-error response never coincide. The decode error is reported the cycle after the completion response.
- `pwrite`, `paddr`, `pwdata` and `pstrb` hold their last values in IDLE.
- `psel` and `penable` are 0 in IDLE.

## Timing
- Reset values: every output 0, including `req_ready`; state IDLE. `req_ready` goes high the first cycle after `preset` deasserts.
- Request accepted at edge N: SETUP in cycle N+1, ACCESS from N+2.
- Completion edge M (ACCESS with `pready`=1): `rsp_valid` is high in cycle M+1 for exactly one cycle.
- Zero-wait back-to-back throughput: one transfer per 2 cycles.
- `preset` asserted mid-transfer takes precedence at the next edge: the transfer is dropped with no response, and all outputs return to reset values.
- `pready` from non-selected slaves is ignored.
- `pready` is ignored in SETUP.

## Configuration
- `APB_MASTER_TIMEOUT_EN` defined:
  - A counter clears on SETUP and increments each ACCESS cycle with `pready`=0.
  - When it reaches `TIMEOUT_CYCLES`, the next edge drops `psel`/`penable`, goes to IDLE, and pulses `rsp_valid`, `rsp_err` and `rsp_timeout` (`rsp_rdata`=0).
  - A `pready` arriving on the limit cycle wins: normal completion, no timeout.
- Undefined: there is no counter, ACCESS waits indefinitely, and `rsp_timeout` is tied 0.

## Structure
- Shared package `apb_pkg`: state enum (IDLE/SETUP/ACCESS), the `APB_SEL_W(n)` clog2 helper constant function, and response-code constants (OKAY, SLVERR, DECERR, TIMEOUT).
- One sub-module, `apb_slave_mux`: combinational decode of idx to one-hot `psel` plus the mapped flag, and the `pready`/`prdata`/`pslverr` return mux.

## Test plan
- Write of 0xDEADBEEF to 0x0000_1004 with strb 0xF and slave 1 `pready` at the first ACCESS:
  - `psel`=4'b0010, SETUP then ACCESS 1 cycle each.
  - Exactly one `rsp_valid` with `rsp_err`=0.
  - `pstrb`=0xF held through ACCESS.
- Read from 0x0000_3000 with slave 3 inserting 3 wait states and returning 0x12345678:
  - Bus fields stable across waits.
  - `rsp_rdata`=0x12345678 the cycle after `pready`.
  - `pstrb`=0.
- Two back-to-back writes with `req_valid` held:
  - Second SETUP in the cycle after the first ACCESS completes.
  - Two responses 2 cycles apart.
- NUM_SLAVES=3, request to 0x0000_3000 (idx 3): no `psel` activity, `rsp_err`=1, `rsp_rdata`=0 one cycle after accept.
- Slave 0 returns `pslverr`=1 on a read: `rsp_err`=1, `rsp_rdata`=0, `rsp_timeout`=0.
- `APB_MASTER_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8, `pready` never asserted:
  - Abort after 8 ACCESS cycles with `rsp_err`=`rsp_timeout`=1.
  - Separately, `preset` pulsed during ACCESS gives all outputs 0 with no `rsp_valid`.
